// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the two-requester shared-register arbiter
package arb_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;
    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W = 4;
endpackage

// File: rtl/en_reg.sv
// en_reg: WIDTH-bit register with synchronous active-high reset and write enable
module en_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_d, data_q;
    always_comb data_d = en ? d : data_q;
    always_ff @(posedge CLK) begin
        if (Reset) data_q <= '0;
        else data_q <= data_d;
    end
    assign q = data_q;
endmodule

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin arbiter granting two requesters write access to one shared register
module reg_share_arb
    import arb_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] Q,
    output logic             owner,
    output logic             busy,
    output logic [7:0]       wr_count
);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [1:0]       gnt_d, gnt_q;
    logic             owner_d, owner_q;
    logic [7:0]       wr_count_d, wr_count_q;
    logic             grant, win;
    logic [WIDTH-1:0] wdata;
    always_comb begin
        grant      = (state_q == IDLE) && (|req);
        win        = (&req) ? ~owner_q : req[1];
        wdata      = win ? data1 : data0;
        cnt_d      = grant ? HOLD_LD : (state_q == HOLD) ? cnt_q - CNT_W'(1) : cnt_q;
        state_d    = grant ? HOLD : (state_q == HOLD && cnt_d == '0) ? IDLE : state_q;
        gnt_d      = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
        owner_d    = grant ? win : owner_q;
        wr_count_d = grant ? wr_count_q + 8'd1 : wr_count_q;
    end
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_q      <= 2'b00;
            owner_q    <= 1'b1;
            wr_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            wr_count_q <= wr_count_d;
        end
    end
    en_reg #(.WIDTH(WIDTH)) u_reg (
        .CLK  (CLK),
        .Reset(Reset),
        .en   (grant),
        .d    (wdata),
        .q    (Q)
    );
    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign busy     = (state_q == HOLD);
    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_reg_share_arb.sv
// tb_reg_share_arb: table-driven and directed checks of reg_share_arb with HOLD_CYCLES of 1 and 3
module tb_reg_share_arb;
    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic [1:0] gnt1, gnt3;
    logic [7:0] q1, q3, wc1, wc3;
    logic       own1, own3, busy1, busy3;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    reg_share_arb #(.WIDTH(8), .HOLD_CYCLES(1)) dut1 (
        .CLK(CLK), .Reset(Reset), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt1), .Q(q1), .owner(own1), .busy(busy1), .wr_count(wc1)
    );
    reg_share_arb #(.WIDTH(8), .HOLD_CYCLES(3)) dut3 (
        .CLK(CLK), .Reset(Reset), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt3), .Q(q3), .owner(own3), .busy(busy3), .wr_count(wc3)
    );

    typedef struct packed {
        logic       rst;
        logic [1:0] rq;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] g;
        logic [7:0] q;
        logic       o;
        logic       b;
        logic [7:0] w;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] rq, input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        Reset = r; req = rq; data0 = a; data1 = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic exp1(input string t, input logic [1:0] g, input logic [7:0] q, input logic o, input logic b, input logic [7:0] w);
        chk({t, ".gnt"}, 32'(gnt1), 32'(g));
        chk({t, ".Q"}, 32'(q1), 32'(q));
        chk({t, ".owner"}, 32'(own1), 32'(o));
        chk({t, ".busy"}, 32'(busy1), 32'(b));
        chk({t, ".wr_count"}, 32'(wc1), 32'(w));
    endtask

    task automatic exp3(input string t, input logic [1:0] g, input logic [7:0] q, input logic o, input logic b, input logic [7:0] w);
        chk({t, ".gnt"}, 32'(gnt3), 32'(g));
        chk({t, ".Q"}, 32'(q3), 32'(q));
        chk({t, ".owner"}, 32'(own3), 32'(o));
        chk({t, ".busy"}, 32'(busy3), 32'(b));
        chk({t, ".wr_count"}, 32'(wc3), 32'(w));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b11, 8'hAA, 8'h00, 2'b00, 8'h00, 1'b1, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 2'b11, 8'hAA, 8'h00, 2'b00, 8'h00, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 2'b01, 8'h5A, 8'h00, 2'b01, 8'h5A, 1'b0, 1'b1, 8'd1};
        vecs[3]  = '{1'b0, 2'b00, 8'h5A, 8'h00, 2'b00, 8'h5A, 1'b0, 1'b0, 8'd1};
        vecs[4]  = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 2'b11, 8'h11, 8'h22, 2'b01, 8'h11, 1'b0, 1'b1, 8'd1};
        vecs[6]  = '{1'b0, 2'b11, 8'h11, 8'h22, 2'b00, 8'h11, 1'b0, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 2'b11, 8'h11, 8'h22, 2'b10, 8'h22, 1'b1, 1'b1, 8'd2};
        vecs[8]  = '{1'b0, 2'b11, 8'h11, 8'h22, 2'b00, 8'h22, 1'b1, 1'b0, 8'd2};
        vecs[9]  = '{1'b0, 2'b11, 8'h11, 8'h22, 2'b01, 8'h11, 1'b0, 1'b1, 8'd3};
        vecs[10] = '{1'b0, 2'b00, 8'h99, 8'h88, 2'b00, 8'h11, 1'b0, 1'b0, 8'd3};
        vecs[11] = '{1'b0, 2'b10, 8'h99, 8'h33, 2'b10, 8'h33, 1'b1, 1'b1, 8'd4};
        vecs[12] = '{1'b0, 2'b01, 8'h44, 8'h33, 2'b00, 8'h33, 1'b1, 1'b0, 8'd4};
        vecs[13] = '{1'b0, 2'b00, 8'h55, 8'h66, 2'b00, 8'h33, 1'b1, 1'b0, 8'd4};
        vecs[14] = '{1'b1, 2'b01, 8'h77, 8'h00, 2'b00, 8'h00, 1'b1, 1'b0, 8'd0};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].rq, vecs[i].d0, vecs[i].d1);
            exp1($sformatf("vec%0d", i), vecs[i].g, vecs[i].q, vecs[i].o, vecs[i].b, vecs[i].w);
        end

        drive(1'b1, 2'b00, 8'h00, 8'h00);
        drive(1'b0, 2'b01, 8'h12, 8'h00);
        exp3("hold_grant", 2'b01, 8'h12, 1'b0, 1'b1, 8'd1);
        drive(1'b0, 2'b10, 8'h12, 8'hFF);
        exp3("hold_c1", 2'b00, 8'h12, 1'b0, 1'b1, 8'd1);
        drive(1'b0, 2'b10, 8'h12, 8'hFF);
        exp3("hold_c2", 2'b00, 8'h12, 1'b0, 1'b1, 8'd1);
        drive(1'b0, 2'b10, 8'h12, 8'hFF);
        exp3("hold_c3", 2'b00, 8'h12, 1'b0, 1'b0, 8'd1);
        drive(1'b0, 2'b10, 8'h12, 8'hFF);
        exp3("hold_next", 2'b10, 8'hFF, 1'b1, 1'b1, 8'd2);

        drive(1'b1, 2'b00, 8'h00, 8'h00);
        drive(1'b0, 2'b01, 8'h21, 8'h00);
        exp3("mid_grant", 2'b01, 8'h21, 1'b0, 1'b1, 8'd1);
        drive(1'b0, 2'b10, 8'h21, 8'h66);
        exp3("mid_h2", 2'b00, 8'h21, 1'b0, 1'b1, 8'd1);
        drive(1'b1, 2'b10, 8'h21, 8'h66);
        exp3("mid_rst", 2'b00, 8'h00, 1'b1, 1'b0, 8'd0);
        drive(1'b0, 2'b10, 8'h21, 8'h66);
        exp3("mid_rel_r1", 2'b10, 8'h66, 1'b1, 1'b1, 8'd1);
        drive(1'b1, 2'b00, 8'h00, 8'h00);
        drive(1'b0, 2'b11, 8'h77, 8'h88);
        exp3("mid_rel_tie", 2'b01, 8'h77, 1'b0, 1'b1, 8'd1);

        drive(1'b1, 2'b00, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 2'b01, 8'(i), 8'h00);
            if (i == 254) chk("wrap_255", 32'(wc1), 32'd255);
            drive(1'b0, 2'b00, 8'h00, 8'h00);
        end
        chk("wrap_count", 32'(wc1), 32'd0);
        chk("wrap_Q", 32'(q1), 32'hFF);
        chk("wrap_busy", 32'(busy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
